// File: rtl/mwaxis_port_hub.sv
// mwaxis_port_hub
//   Bridges one byte-wide packet stream to NUM_CHANNELS AXIS channel pairs,
//   keyed on a 16-bit UDP destination port carried in the first two bytes.
//   Ingress: the 2-byte header picks the channel (DSTPORT_BASE + i). The
//   payload is then passed straight through to that channel. Packets to an
//   unknown port or a disabled channel are dropped, as are runts (tlast on a
//   header byte).
//   Egress: round-robin arbitration over enabled, valid channels. Each granted
//   packet is prefixed with its channel's port number and then passed through.
// Ports
//   dutclk, reset        clock, synchronous active-high reset
//   rx_*                 ingress stream (header + payload)
//   m_axis_*             per-channel ingress payload, channel i in byte lane i
//   s_axis_*             per-channel egress payload, channel i in byte lane i
//   chan_en              per-channel enable for routing and arbitration
//   tx_*                 egress stream (header + payload)
//   rx_drop_cnt          dropped ingress packets, saturating
//   tx_pkt_cnt           completed egress packets, wrapping

// Per-channel steering: when a lane is not selected, its outputs are quiet.
module mwaxis_port_lane (
   input  logic       rx_on,
   input  logic       tx_on,
   input  logic [7:0] rx_tdata,
   input  logic       rx_tvalid,
   input  logic       rx_tlast,
   input  logic       tx_tready,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   output logic       m_tlast,
   output logic       s_tready
);
   assign m_tdata  = rx_on ? rx_tdata : 8'h00;
   assign m_tvalid = rx_on & rx_tvalid;
   assign m_tlast  = rx_on & rx_tlast;
   assign s_tready = tx_on & tx_tready;
endmodule

module mwaxis_port_hub #(
   parameter int NUM_CHANNELS = 8,
   parameter int DSTPORT_BASE = 50101,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                      dutclk,
   input  logic                      reset,
   input  logic [7:0]                rx_tdata,
   input  logic                      rx_tvalid,
   input  logic                      rx_tlast,
   output logic                      rx_tready,
   output logic [8*NUM_CHANNELS-1:0] m_axis_tdata,
   output logic [NUM_CHANNELS-1:0]   m_axis_tvalid,
   output logic [NUM_CHANNELS-1:0]   m_axis_tlast,
   input  logic [NUM_CHANNELS-1:0]   m_axis_tready,
   input  logic [8*NUM_CHANNELS-1:0] s_axis_tdata,
   input  logic [NUM_CHANNELS-1:0]   s_axis_tvalid,
   input  logic [NUM_CHANNELS-1:0]   s_axis_tlast,
   output logic [NUM_CHANNELS-1:0]   s_axis_tready,
   input  logic [NUM_CHANNELS-1:0]   chan_en,
   output logic [7:0]                tx_tdata,
   output logic                      tx_tvalid,
   output logic                      tx_tlast,
   input  logic                      tx_tready,
   output logic [CNT_WIDTH-1:0]      rx_drop_cnt,
   output logic [CNT_WIDTH-1:0]      tx_pkt_cnt
);
   localparam int          SW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [15:0] BASE = 16'(DSTPORT_BASE);

   typedef enum logic [1:0] {RX_HDR0, RX_HDR1, RX_PAYLOAD, RX_DROP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_HDR0, TX_HDR1, TX_PAYLOAD} tx_state_t;

   rx_state_t rx_state;
   tx_state_t tx_state;
   logic [7:0]    port_hi;
   logic [SW-1:0] sel, grant, last_grant, rx_idx, tx_pick;
   logic          rx_hit, tx_found, rx_acc, tx_acc, rx_drop_ev;
   logic [15:0]   rx_off, tx_hdr;
   logic [NUM_CHANNELS-1:0] req;
   logic [NUM_CHANNELS-1:0][7:0] s_data, m_data;
   int            rr_idx;

   assign s_data       = s_axis_tdata;
   assign m_axis_tdata = m_data;

   // ---------------- ingress ----------------
   // Offset of the received port from the base; only in-range, enabled hits route.
   assign rx_off = {port_hi, rx_tdata} - BASE;

   always_comb begin
      rx_hit = 1'b0;
      rx_idx = '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
         if (rx_off == 16'(i) && chan_en[i]) begin
            rx_hit = 1'b1;
            rx_idx = SW'(i);
         end
   end

   always_comb begin
      rx_tready = 1'b0;
      if (!reset)
         rx_tready = (rx_state == RX_PAYLOAD) ? m_axis_tready[sel] : 1'b1;
   end

   assign rx_acc = rx_tvalid & rx_tready;
   // Any packet ending outside the payload state was dropped (bad port or runt).
   assign rx_drop_ev = rx_acc & rx_tlast & (rx_state != RX_PAYLOAD);

   always_ff @(posedge dutclk) begin
      if (reset) begin
         rx_state    <= RX_HDR0;
         port_hi     <= '0;
         sel         <= '0;
         rx_drop_cnt <= '0;
      end else begin
         if (rx_drop_ev && rx_drop_cnt != {CNT_WIDTH{1'b1}})
            rx_drop_cnt <= rx_drop_cnt + CNT_WIDTH'(1);
         if (rx_acc) begin
            unique case (rx_state)
               RX_HDR0: if (!rx_tlast) begin
                  port_hi  <= rx_tdata;
                  rx_state <= RX_HDR1;
               end
               RX_HDR1: begin
                  if (rx_tlast)    rx_state <= RX_HDR0;
                  else if (rx_hit) begin
                     sel      <= rx_idx;
                     rx_state <= RX_PAYLOAD;
                  end else         rx_state <= RX_DROP;
               end
               RX_PAYLOAD, RX_DROP: if (rx_tlast) rx_state <= RX_HDR0;
               default: rx_state <= RX_HDR0;
            endcase
         end
      end
   end

   // ---------------- egress ----------------
   assign req    = s_axis_tvalid & chan_en;
   assign tx_hdr = BASE + 16'(grant);

   // Round-robin: first requester strictly after last_grant, wrapping.
   always_comb begin
      tx_found = 1'b0;
      tx_pick  = '0;
      rr_idx   = 0;
      for (int k = 1; k <= NUM_CHANNELS; k++) begin
         rr_idx = (int'(last_grant) + k) % NUM_CHANNELS;
         if (!tx_found && req[rr_idx]) begin
            tx_found = 1'b1;
            tx_pick  = SW'(rr_idx);
         end
      end
   end

   always_comb begin
      tx_tvalid = 1'b0;
      tx_tlast  = 1'b0;
      tx_tdata  = 8'h00;
      if (!reset) begin
         unique case (tx_state)
            TX_HDR0: begin tx_tvalid = 1'b1; tx_tdata = tx_hdr[15:8]; end
            TX_HDR1: begin tx_tvalid = 1'b1; tx_tdata = tx_hdr[7:0];  end
            TX_PAYLOAD: begin
               tx_tvalid = s_axis_tvalid[grant];
               tx_tlast  = s_axis_tlast[grant];
               tx_tdata  = s_data[grant];
            end
            default: ;
         endcase
      end
   end

   assign tx_acc = tx_tvalid & tx_tready;

   always_ff @(posedge dutclk) begin
      if (reset) begin
         tx_state   <= TX_IDLE;
         grant      <= '0;
         last_grant <= SW'(NUM_CHANNELS - 1);
         tx_pkt_cnt <= '0;
      end else begin
         unique case (tx_state)
            TX_IDLE: if (tx_found) begin
               grant      <= tx_pick;
               last_grant <= tx_pick;
               tx_state   <= TX_HDR0;
            end
            TX_HDR0: if (tx_tready) tx_state <= TX_HDR1;
            TX_HDR1: if (tx_tready) tx_state <= TX_PAYLOAD;
            TX_PAYLOAD: if (tx_acc && tx_tlast) begin
               tx_pkt_cnt <= tx_pkt_cnt + CNT_WIDTH'(1);
               tx_state   <= TX_IDLE;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- per-channel steering ----------------
   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
      mwaxis_port_lane u_lane (
         .rx_on    (!reset && rx_state == RX_PAYLOAD && sel == SW'(g)),
         .tx_on    (!reset && tx_state == TX_PAYLOAD && grant == SW'(g)),
         .rx_tdata (rx_tdata),
         .rx_tvalid(rx_tvalid),
         .rx_tlast (rx_tlast),
         .tx_tready(tx_tready),
         .m_tdata  (m_data[g]),
         .m_tvalid (m_axis_tvalid[g]),
         .m_tlast  (m_axis_tlast[g]),
         .s_tready (s_axis_tready[g])
      );
   end
endmodule

// File: tb/tb_mwaxis_port_hub.sv
module tb_mwaxis_port_hub;
   localparam int NCH = 8;
   localparam int CW  = 3;   // narrow counters so saturation and wrap are reachable

   typedef struct packed { logic [3:0] ch; logic last; logic [7:0] d; } rx_rec_t;

   logic dutclk = 1'b0;
   logic reset;
   logic [7:0] rx_tdata;
   logic rx_tvalid, rx_tlast, rx_tready;
   logic [8*NCH-1:0] m_axis_tdata;
   logic [NCH-1:0] m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [8*NCH-1:0] s_axis_tdata = '0;
   logic [NCH-1:0] s_axis_tvalid = '0;
   logic [NCH-1:0] s_axis_tlast = '0;
   logic [NCH-1:0] s_axis_tready;
   logic [NCH-1:0] chan_en;
   logic [7:0] tx_tdata;
   logic tx_tvalid, tx_tlast;
   logic tx_tready = 1'b1;
   logic [CW-1:0] rx_drop_cnt, tx_pkt_cnt;

   always #5 dutclk = ~dutclk;

   mwaxis_port_hub #(.NUM_CHANNELS(NCH), .DSTPORT_BASE(50101), .CNT_WIDTH(CW)) dut (
      .dutclk(dutclk), .reset(reset),
      .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .chan_en(chan_en),
      .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
      .rx_drop_cnt(rx_drop_cnt), .tx_pkt_cnt(tx_pkt_cnt)
   );

   int n_chk = 0, n_pass = 0;
   rx_rec_t rxq[$];
   logic [8:0] txq[$];
   int mv_cnt = 0, txv_cnt = 0;
   logic [7:0] src_d [NCH][16];
   int src_len [NCH];
   int src_ptr [NCH];
   logic tx_toggle = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Handshakes seen at the negedge complete at the following posedge.
   always @(negedge dutclk) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++)
            if (m_axis_tvalid[i] && m_axis_tready[i])
               rxq.push_back({4'(i), m_axis_tlast[i], m_axis_tdata[8*i +: 8]});
         if (|m_axis_tvalid) mv_cnt++;
         if (tx_tvalid && tx_tready) txq.push_back({tx_tlast, tx_tdata});
         if (tx_tvalid) txv_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge dutclk);
      #1;
   endtask

   // Per-channel egress sources plus the tx_tready pattern.
   task automatic src_proc();
      logic [NCH-1:0] acc;
      forever begin
         @(negedge dutclk);
         acc = s_axis_tvalid & s_axis_tready;
         @(posedge dutclk);
         #1;
         for (int i = 0; i < NCH; i++) begin
            if (acc[i]) src_ptr[i]++;
            s_axis_tvalid[i] = (src_ptr[i] < src_len[i]);
            s_axis_tlast[i]  = (src_ptr[i] == src_len[i] - 1);
            s_axis_tdata[8*i +: 8] = (src_ptr[i] < 16) ? src_d[i][src_ptr[i]] : 8'h00;
         end
         tx_tready = tx_toggle ? ~tx_tready : 1'b1;
      end
   endtask

   task automatic load(input int ch, input logic [7:0] b0, input int n);
      for (int j = 0; j < n; j++) src_d[ch][j] = b0 + 8'(j);
      src_ptr[ch] = 0;
      src_len[ch] = n;
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic last);
      int t;
      logic r;
      rx_tdata = d; rx_tvalid = 1'b1; rx_tlast = last;
      t = 0;
      forever begin
         @(negedge dutclk);
         r = rx_tready;
         @(posedge dutclk);
         #1;
         if (r) break;
         t++;
         if (t > 200) begin
            chk("rx_accept_timeout", 32'(t), 32'd0);
            break;
         end
      end
      rx_tvalid = 1'b0; rx_tlast = 1'b0;
   endtask

   task automatic wait_txq(input int n);
      int t;
      t = 0;
      while (txq.size() < n && t < 400) begin tick(1); t++; end
      chk("txq_wait", 32'(txq.size() >= n), 32'd1);
   endtask

   task automatic tx_exp(input string tag, input int base, input logic [8:0] e[$]);
      chk({tag, "_len"}, 32'(txq.size() - base), 32'(e.size()));
      for (int j = 0; j < e.size(); j++)
         chk($sformatf("%s_%0d", tag, j),
             (base + j < txq.size()) ? 32'(txq[base + j]) : 32'hFFFF_FFFF, 32'(e[j]));
   endtask

   task automatic rx_exp(input string tag, input int idx, input int ch, input logic last,
                         input logic [7:0] d);
      chk(tag, (idx < rxq.size()) ? 32'(rxq[idx]) : 32'hFFFF_FFFF, 32'({4'(ch), last, d}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [8:0] e[$];
      int b, r, t, m;
      logic lastor;
      reset = 1'b1; rx_tdata = '0; rx_tvalid = 1'b0; rx_tlast = 1'b0;
      m_axis_tready = '1; chan_en = '1;
      for (int i = 0; i < NCH; i++) begin src_len[i] = 0; src_ptr[i] = 0; end
      fork src_proc(); join_none

      // reset state
      tick(3);
      @(negedge dutclk);
      chk("rst_rx_tready", 32'(rx_tready), 0);
      chk("rst_m_tvalid",  32'(m_axis_tvalid), 0);
      chk("rst_s_tready",  32'(s_axis_tready), 0);
      chk("rst_tx_tvalid", 32'(tx_tvalid), 0);
      chk("rst_tx_tlast",  32'(tx_tlast), 0);
      chk("rst_drop_cnt",  32'(rx_drop_cnt), 0);
      chk("rst_pkt_cnt",   32'(tx_pkt_cnt), 0);
      tick(1);
      reset = 1'b0;
      tick(1);

      // route to ch2 (port 50103 = C3B7)
      b = rxq.size();
      rx_byte(8'hC3, 0); rx_byte(8'hB7, 0); rx_byte(8'h11, 0); rx_byte(8'h22, 1);
      tick(2);
      chk("route_len", 32'(rxq.size() - b), 2);
      rx_exp("route_b0", b, 2, 0, 8'h11);
      rx_exp("route_b1", b + 1, 2, 1, 8'h22);
      chk("route_drop_cnt", 32'(rx_drop_cnt), 0);

      // unknown port + runt are dropped silently
      m = mv_cnt;
      rx_byte(8'h12, 0); rx_byte(8'h34, 0);
      for (int j = 0; j < 5; j++) rx_byte(8'h40 + 8'(j), j == 4);
      rx_byte(8'hAA, 1);
      tick(1);
      chk("drop_cnt2", 32'(rx_drop_cnt), 2);
      chk("drop_no_tvalid", 32'(mv_cnt - m), 0);
      b = rxq.size();
      rx_byte(8'hC3, 0); rx_byte(8'hB5, 0); rx_byte(8'h55, 0); rx_byte(8'h66, 1);
      tick(2);
      rx_exp("after_drop_b0", b, 0, 0, 8'h55);
      rx_exp("after_drop_b1", b + 1, 0, 1, 8'h66);

      // boundaries: one past the top channel, disabled channel, top channel
      rx_byte(8'hC3, 0); rx_byte(8'hBD, 0); rx_byte(8'h99, 1);
      chan_en[1] = 1'b0;
      rx_byte(8'hC3, 0); rx_byte(8'hB6, 0); rx_byte(8'h98, 1);
      chan_en = '1;
      tick(1);
      chk("drop_range_dis", 32'(rx_drop_cnt), 4);
      b = rxq.size();
      rx_byte(8'hC3, 0); rx_byte(8'hBC, 0); rx_byte(8'h7E, 1);
      tick(2);
      rx_exp("route_ch7", b, 7, 1, 8'h7E);
      // 2-byte runt then more runts: saturates at 7
      rx_byte(8'hC3, 0); rx_byte(8'hB5, 1);
      tick(1);
      chk("drop_hdr1_runt", 32'(rx_drop_cnt), 5);
      for (int j = 0; j < 3; j++) rx_byte(8'hF0, 1);
      tick(1);
      chk("drop_saturate", 32'(rx_drop_cnt), 7);

      // TX round robin ch0, ch3, ch7
      b = txq.size();
      load(0, 8'h01, 3); load(3, 8'h31, 3); load(7, 8'h71, 3);
      wait_txq(b + 15);
      e = '{9'h0C3, 9'h0B5, 9'h001, 9'h002, 9'h103,
            9'h0C3, 9'h0B8, 9'h031, 9'h032, 9'h133,
            9'h0C3, 9'h0BC, 9'h071, 9'h072, 9'h173};
      tx_exp("rr", b, e);
      tick(1);
      chk("rr_pkt_cnt", 32'(tx_pkt_cnt), 3);

      // Backpressure on both sides, RX and TX concurrently
      b = txq.size(); r = rxq.size();
      tx_toggle = 1'b1;
      load(2, 8'h21, 3); load(5, 8'h51, 2);
      fork
         begin
            rx_byte(8'hC3, 0); rx_byte(8'hB7, 0);
            for (int j = 0; j < 4; j++) rx_byte(8'hA1 + 8'(j), j == 3);
         end
         begin
            tick(3);
            m_axis_tready[2] = 1'b0;
            @(negedge dutclk);
            chk("stall_rx_tready", 32'(rx_tready), 0);
            tick(9);
            m_axis_tready[2] = 1'b1;
         end
      join
      wait_txq(b + 9);
      tx_toggle = 1'b0;
      tick(2);
      e = '{9'h0C3, 9'h0B7, 9'h021, 9'h022, 9'h123, 9'h0C3, 9'h0BA, 9'h051, 9'h152};
      tx_exp("bp_tx", b, e);
      chk("bp_pkt_cnt", 32'(tx_pkt_cnt), 5);
      chk("bp_rx_len", 32'(rxq.size() - r), 4);
      for (int j = 0; j < 4; j++)
         rx_exp($sformatf("bp_rx_%0d", j), r + j, 2, j == 3, 8'hA1 + 8'(j));

      // chan_en[3] dropped mid-packet: packet completes, ch3 not granted again
      b = txq.size();
      load(3, 8'h3A, 4);
      t = 0;
      while (!tx_tvalid && t < 100) begin @(negedge dutclk); t++; end
      chan_en[3] = 1'b0;
      chk("hold_start", 32'(t < 100), 1);
      tick(1);
      wait_txq(b + 6);
      e = '{9'h0C3, 9'h0B8, 9'h03A, 9'h03B, 9'h03C, 9'h13D};
      tx_exp("hold", b, e);
      load(3, 8'hE0, 1);
      t = txv_cnt;
      tick(20);
      chk("masked_no_tx", 32'(txv_cnt - t), 0);
      @(negedge dutclk);
      chk("masked_s_tready", 32'(s_axis_tready), 0);
      tick(1);
      b = txq.size();
      load(4, 8'h41, 1);
      wait_txq(b + 3);
      e = '{9'h0C3, 9'h0B9, 9'h141};
      tx_exp("ch4", b, e);
      b = txq.size();
      load(0, 8'h09, 1);
      wait_txq(b + 3);
      e = '{9'h0C3, 9'h0B5, 9'h109};
      tx_exp("ch0_wrap", b, e);
      tick(1);
      chk("pkt_wrap", 32'(tx_pkt_cnt), 0);

      // Reset mid-packet on RX and TX
      src_len[3] = 0; src_ptr[3] = 0;
      tick(2);
      chan_en = '1;
      b = txq.size();
      load(1, 8'h11, 1);
      wait_txq(b + 3);
      e = '{9'h0C3, 9'h0B6, 9'h111};
      tx_exp("pre_rst", b, e);
      tick(1);
      chk("pre_rst_pkt_cnt", 32'(tx_pkt_cnt), 1);
      b = txq.size(); r = rxq.size();
      load(6, 8'h60, 8);
      rx_byte(8'hC3, 0); rx_byte(8'hB5, 0); rx_byte(8'h5A, 0);
      m_axis_tready[0] = 1'b0;
      rx_tdata = 8'h5B; rx_tvalid = 1'b1;
      t = 0;
      while (txq.size() < b + 4 && t < 100) begin tick(1); t++; end
      reset = 1'b1;
      for (int i = 0; i < NCH; i++) begin src_len[i] = 0; src_ptr[i] = 0; end
      @(negedge dutclk);
      chk("midrst_rx_tready", 32'(rx_tready), 0);
      chk("midrst_m_tvalid",  32'(m_axis_tvalid), 0);
      chk("midrst_tx_tvalid", 32'(tx_tvalid), 0);
      chk("midrst_tx_tlast",  32'(tx_tlast), 0);
      chk("midrst_s_tready",  32'(s_axis_tready), 0);
      tick(2);
      chk("midrst_drop_cnt", 32'(rx_drop_cnt), 0);
      chk("midrst_pkt_cnt",  32'(tx_pkt_cnt), 0);
      lastor = 1'b0;
      for (int j = b; j < txq.size(); j++) lastor |= txq[j][8];
      chk("abandon_no_tlast", 32'(lastor), 0);
      chk("abandon_rx_len", 32'(rxq.size() - r), 1);
      rx_exp("abandon_rx_b0", r, 0, 0, 8'h5A);
      rx_tvalid = 1'b0;
      m_axis_tready = '1;
      reset = 1'b0;
      tick(1);
      r = rxq.size();
      rx_byte(8'hC3, 0); rx_byte(8'hB6, 0); rx_byte(8'h77, 1);
      tick(2);
      chk("post_rst_rx_len", 32'(rxq.size() - r), 1);
      rx_exp("post_rst_route", r, 1, 1, 8'h77);
      b = txq.size();
      load(6, 8'hD6, 1); load(2, 8'hD2, 1);
      wait_txq(b + 6);
      e = '{9'h0C3, 9'h0B7, 9'h1D2, 9'h0C3, 9'h0BB, 9'h1D6};
      tx_exp("post_rst_rr", b, e);
      tick(1);
      chk("post_rst_pkt_cnt", 32'(tx_pkt_cnt), 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
